// File: rtl/mask_data_credit.sv
// Byte-mask stage with a credit counter: each accepted beat either has its keep
// vector trimmed to the available credits (MODE 0) or waits for credits (MODE 1).
module mask_data_credit #(
    parameter int BUSBYTEWIDTH = 16,
    parameter int CREDITMAX    = 32,
    parameter int CREDITINIT   = 32,
    parameter int MODE         = 0,
    localparam int CW          = $clog2(CREDITMAX + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      credretvld,
    input  logic [CW-1:0]             credret,
    input  logic                      businvld,
    output logic                      businrdy,
    input  logic [BUSBYTEWIDTH-1:0]   businkeep,
    input  logic [BUSBYTEWIDTH*8-1:0] busin,
    input  logic                      businlast,
    output logic                      busoutvld,
    input  logic                      busoutrdy,
    output logic [BUSBYTEWIDTH-1:0]   busoutkeep,
    output logic [BUSBYTEWIDTH*8-1:0] busout,
    output logic                      busoutlast,
    output logic                      busouttrunc,
    output logic [CW-1:0]             credits,
    output logic                      credovf
);

    localparam logic [CW:0] CMAX = (CW+1)'(CREDITMAX);

    logic [CW-1:0]           pcnt;
    logic [CW-1:0]           rank;
    logic [BUSBYTEWIDTH-1:0] keep_mask;
    logic [BUSBYTEWIDTH-1:0] keep_next;
    logic                    trunc_next;
    logic [CW-1:0]           consumed;
    logic                    rdy_base;
    logic                    accept;
    logic [CW:0]             sum;

    // Keep only set bits whose rank is below the registered credit count
    always_comb begin
        pcnt      = '0;
        rank      = '0;
        keep_mask = '0;
        for (int i = 0; i < BUSBYTEWIDTH; i++) begin
            if (businkeep[i]) begin
                if (rank < credits)
                    keep_mask[i] = 1'b1;
                rank = rank + CW'(1);
                pcnt = pcnt + CW'(1);
            end
        end
    end

    always_comb begin
        rdy_base = !busoutvld || busoutrdy;
        if (MODE == 0) begin
            businrdy   = rdy_base;
            keep_next  = keep_mask;
            trunc_next = (keep_mask != businkeep);
            consumed   = (credits < pcnt) ? credits : pcnt;
        end else begin
            businrdy   = rdy_base && (credits >= pcnt);
            keep_next  = businkeep;
            trunc_next = 1'b0;
            consumed   = pcnt;
        end
        accept = businvld && businrdy;
    end

    // consumed never exceeds credits, so the difference cannot wrap
    always_comb begin
        sum = {1'b0, credits};
        if (accept)
            sum = sum - {1'b0, consumed};
        if (credretvld)
            sum = sum + {1'b0, credret};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busoutvld   <= 1'b0;
            busoutkeep  <= '0;
            busout      <= '0;
            busoutlast  <= 1'b0;
            busouttrunc <= 1'b0;
        end else if (accept) begin
            busoutvld   <= 1'b1;
            busoutkeep  <= keep_next;
            busout      <= busin;
            busoutlast  <= businlast;
            busouttrunc <= trunc_next;
        end else if (busoutrdy) begin
            busoutvld   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= CW'(CREDITINIT);
            credovf <= 1'b0;
        end else if (sum > CMAX) begin
            credits <= CW'(CREDITMAX);
            credovf <= 1'b1;
        end else begin
            credits <= sum[CW-1:0];
        end
    end

endmodule

// File: tb/tb_mask_data_credit.sv
// Directed bench for mask_data_credit: a truncating instance (a_*) and a
// stalling instance (b_*) share clock and reset.
module tb_mask_data_credit;

    localparam int BW = 16;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_crv, a_ivld, a_irdy, a_ilast, a_ovld, a_ordy;
    logic            a_olast, a_otrunc, a_ovf;
    logic [CW-1:0]   a_cr, a_cred;
    logic [BW-1:0]   a_ikeep, a_okeep;
    logic [BW*8-1:0] a_idata, a_odata;

    logic            b_crv, b_ivld, b_irdy, b_ilast, b_ovld, b_ordy;
    logic            b_olast, b_otrunc, b_ovf;
    logic [CW-1:0]   b_cr, b_cred;
    logic [BW-1:0]   b_ikeep, b_okeep;
    logic [BW*8-1:0] b_idata, b_odata;

    mask_data_credit #(.MODE(0)) u_a (
        .clk(clk), .reset(rst),
        .credretvld(a_crv), .credret(a_cr),
        .businvld(a_ivld), .businrdy(a_irdy),
        .businkeep(a_ikeep), .busin(a_idata), .businlast(a_ilast),
        .busoutvld(a_ovld), .busoutrdy(a_ordy),
        .busoutkeep(a_okeep), .busout(a_odata), .busoutlast(a_olast),
        .busouttrunc(a_otrunc), .credits(a_cred), .credovf(a_ovf)
    );

    mask_data_credit #(.MODE(1)) u_b (
        .clk(clk), .reset(rst),
        .credretvld(b_crv), .credret(b_cr),
        .businvld(b_ivld), .businrdy(b_irdy),
        .businkeep(b_ikeep), .busin(b_idata), .businlast(b_ilast),
        .busoutvld(b_ovld), .busoutrdy(b_ordy),
        .busoutkeep(b_okeep), .busout(b_odata), .busoutlast(b_olast),
        .busouttrunc(b_otrunc), .credits(b_cred), .credovf(b_ovf)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    localparam logic [127:0] DX = {4{32'h1234_5678}};
    localparam logic [127:0] DY = {4{32'hCAFE_F00D}};
    localparam logic [127:0] DZ = {4{32'h0BAD_BEEF}};

    initial begin
        a_crv = 0; a_cr = '0; a_ivld = 0; a_ikeep = '0; a_idata = '0;
        a_ilast = 0; a_ordy = 1;
        b_crv = 0; b_cr = '0; b_ivld = 0; b_ikeep = '0; b_idata = '0;
        b_ilast = 0; b_ordy = 1;

        repeat (2) @(negedge clk);
        check("rst_vld", a_ovld, 0);
        check("rst_keep", a_okeep, 0);
        check("rst_data", a_odata, 0);
        check("rst_cred", a_cred, 32);
        check("rst_ovf", a_ovf, 0);
        rst = 0;

        // three full beats against 32 credits
        a_ivld = 1; a_ikeep = 16'hFFFF; a_idata = DX;
        @(negedge clk);
        check("t1_keep0", a_okeep, 16'hFFFF);
        check("t1_trunc0", a_otrunc, 0);
        check("t1_cred0", a_cred, 16);
        check("t1_vld0", a_ovld, 1);
        a_idata = DY;
        @(negedge clk);
        check("t1_keep1", a_okeep, 16'hFFFF);
        check("t1_data1", a_odata, DY);
        check("t1_cred1", a_cred, 0);
        a_ilast = 1;
        @(negedge clk);
        check("t1_keep2", a_okeep, 16'h0000);
        check("t1_trunc2", a_otrunc, 1);
        check("t1_last2", a_olast, 1);
        check("t1_cred2", a_cred, 0);
        a_ivld = 0; a_ilast = 0; a_crv = 1; a_cr = 5;
        @(negedge clk);
        check("t2_cred5", a_cred, 5);
        check("t2_drain", a_ovld, 0);
        a_crv = 0; a_ivld = 1; a_ikeep = 16'hAAAA; a_idata = DZ;
        @(negedge clk);
        check("t2_keep", a_okeep, 16'h02AA);
        check("t2_trunc", a_otrunc, 1);
        check("t2_data", a_odata, DZ);
        check("t2_cred", a_cred, 0);

        // backpressure hold with a return during the hold
        a_ivld = 0; a_crv = 1; a_cr = 16;
        @(negedge clk);
        check("bp_cred16", a_cred, 16);
        a_crv = 0; a_ivld = 1; a_ikeep = 16'h000F; a_idata = DX; a_ordy = 0;
        @(negedge clk);
        check("bp_cred12", a_cred, 12);
        check("bp_keep", a_okeep, 16'h000F);
        a_ikeep = 16'hFFFF; a_idata = DY; a_crv = 1; a_cr = 8;
        #1 check("bp_rdy", a_irdy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_crv = 0;
            check("bp_cred20", a_cred, 20);
            check("bp_vld", a_ovld, 1);
            check("bp_keep_h", a_okeep, 16'h000F);
            check("bp_data_h", a_odata, DX);
            check("bp_rdy_h", a_irdy, 0);
        end
        a_ordy = 1;
        @(negedge clk);
        check("bp_keepY", a_okeep, 16'hFFFF);
        check("bp_dataY", a_odata, DY);
        check("bp_truncY", a_otrunc, 0);
        check("bp_cred4", a_cred, 4);

        // saturation
        a_ivld = 0; a_crv = 1; a_cr = 26;
        @(negedge clk);
        check("sat_cred30", a_cred, 30);
        check("sat_ovf0", a_ovf, 0);
        a_cr = 8;
        @(negedge clk);
        check("sat_cred32", a_cred, 32);
        check("sat_ovf1", a_ovf, 1);
        a_cr = 10; a_ivld = 1; a_ikeep = 16'hFFFF;
        @(negedge clk);
        check("sat_cred26", a_cred, 26);
        check("sat_keep", a_okeep, 16'hFFFF);
        a_crv = 0; a_ivld = 0;
        @(negedge clk);
        check("sat_sticky", a_ovf, 1);
        check("sat_hold26", a_cred, 26);

        // asynchronous reset while a beat is on the output
        a_ivld = 1; a_ikeep = 16'h0001;
        @(posedge clk);
        #1 check("ar_pre_vld", a_ovld, 1);
        #1 rst = 1;
        #1;
        check("ar_vld", a_ovld, 0);
        check("ar_cred", a_cred, 32);
        check("ar_ovf", a_ovf, 0);
        check("ar_keep", a_okeep, 0);
        a_ivld = 0;
        @(negedge clk);
        rst = 0;
        a_ivld = 1; a_ikeep = 16'hFFFF; a_idata = DZ;
        @(negedge clk);
        check("ar_keep1", a_okeep, 16'hFFFF);
        check("ar_cred1", a_cred, 16);
        check("ar_trunc1", a_otrunc, 0);
        a_ivld = 0;

        // stalling instance
        b_ivld = 1; b_ikeep = 16'hFFFF; b_idata = DX;
        @(negedge clk);
        check("m1_cred16", b_cred, 16);
        @(negedge clk);
        check("m1_cred0", b_cred, 0);
        b_ivld = 0; b_crv = 1; b_cr = 4;
        @(negedge clk);
        check("m1_cred4", b_cred, 4);
        b_crv = 0; b_ivld = 1; b_ikeep = 16'h00FF; b_idata = DY;
        #1 check("m1_stall", b_irdy, 0);
        @(negedge clk);
        check("m1_novld", b_ovld, 0);
        check("m1_cred4h", b_cred, 4);
        b_crv = 1; b_cr = 4;
        #1 check("m1_stall2", b_irdy, 0);
        @(negedge clk);
        b_crv = 0;
        check("m1_cred8", b_cred, 8);
        check("m1_novld2", b_ovld, 0);
        #1 check("m1_rdy", b_irdy, 1);
        @(negedge clk);
        check("m1_keep", b_okeep, 16'h00FF);
        check("m1_data", b_odata, DY);
        check("m1_trunc", b_otrunc, 0);
        check("m1_credE", b_cred, 0);
        b_ikeep = 16'h0000;
        #1 check("m1_p0rdy", b_irdy, 1);
        @(negedge clk);
        check("m1_p0vld", b_ovld, 1);
        check("m1_p0keep", b_okeep, 16'h0000);
        check("m1_p0cred", b_cred, 0);
        b_ivld = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mask_data_credit.md
Name: mask_data_credit

Overview:
- Streaming byte-mask stage with a valid/ready handshake.
- Keeps a running byte-credit counter that is replenished by a credit-return port.
- Each accepted beat either has its keep vector truncated to the available credits, or is stalled until enough credits exist.
- Sits between an upstream packet source and a byte-granular storage element such as a FIFO or packer, and replaces the fixed-latency, free-running mask stage.

Parameters:
- BUSBYTEWIDTH, 16, data bus width in bytes (power of two, 2..64).
- CREDITMAX, 32, maximum credit count in bytes (must be >= BUSBYTEWIDTH).
- CREDITINIT, 32, credit count loaded at reset (must be <= CREDITMAX).
- MODE, 0, 0 = truncate excess kept bytes, 1 = stall until credits cover the beat.
- CW (derived, not overridable), $clog2(CREDITMAX+1), width of the credit count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- credretvld  in  1  credit return strobe.
- credret  in  CW  bytes returned; sampled when credretvld=1.
- businvld  in  1  input beat valid.
- businrdy  out  1  input beat ready.
- businkeep  in  BUSBYTEWIDTH  per-byte keep; bit i qualifies byte i.
- busin  in  BUSBYTEWIDTH*8  input data.
- businlast  in  1  last beat of packet.
- busoutvld  out  1  output beat valid.
- busoutrdy  in  1  output beat ready.
- busoutkeep  out  BUSBYTEWIDTH  masked keep.
- busout  out  BUSBYTEWIDTH*8  data; passed through unmodified.
- busoutlast  out  1  registered businlast.
- busouttrunc  out  1  beat had at least one keep bit cleared by masking.
- credits  out  CW  current credit count (registered).
- credovf  out  1  sticky: a credit return was clipped at CREDITMAX.

Behaviour:
- Reset (async assert, sync release): busoutvld=0, busoutkeep=0, busout=0, busoutlast=0, busouttrunc=0, credovf=0, credits=CREDITINIT.
- Handshake:
  - A transfer occurs when vld and rdy are both 1 at a clock edge.
  - vld must not depend on rdy.
  - Output data, keep, last and trunc stay stable while busoutvld=1 and busoutrdy=0.
- Datapath:
  - Single output register stage; accepted input appears at the output on the next cycle.
  - Latency is 1 cycle, with full throughput of 1 beat per cycle when busoutrdy is held at 1.
  - No skid buffer.
  - Base ready: businrdy_base = !busoutvld || busoutrdy.
- Prefix count: P = popcount(businkeep). Keep bits are ranked by ascending index; bit i is "rank r" if it is the (r+1)-th set bit.
- MODE 0 (truncate):
  - businrdy = businrdy_base.
  - A = min(credits, P).
  - busoutkeep retains only set bits of rank < A.
  - busouttrunc = (A < P).
  - consumed = A.
  - With credits=0, the beat is still forwarded with keep=0, trunc = (P != 0), and last preserved.
- MODE 1 (stall):
  - businrdy = businrdy_base && (credits >= P).
  - busoutkeep = businkeep, busouttrunc = 0, consumed = P.
  - A beat with P=0 is never stalled by credits.
- Credit update, every cycle:
  - sum = credits - (accept ? consumed : 0) + (credretvld ? credret : 0), computed at CW+1 bits.
  - If sum > CREDITMAX: credits = CREDITMAX and credovf is set to 1; it is cleared only by reset.
  - The subtraction never underflows, by construction.
- Simultaneous return and consume:
  - Both apply in the same cycle.
  - Masking and the stall check use the registered credits only; a same-cycle return does not help the current beat.
- Hold behaviour: while busoutvld=1 and busoutrdy=0, no input is accepted and credits change only by returns.
- busin and businlast are passed through unmodified.
- Keep bits and data bytes beyond the masked set are not zeroed in data.

Test Plan:
- MODE0, CREDITINIT=32, 3 beats keep=16'hFFFF with busoutrdy=1 -> out keeps FFFF, FFFF, 0000; trunc 0, 0, 1; credits 16, 0, 0; each beat 1 cycle after its input.
- MODE0, credits=5, keep=16'b1010_1010_1010_1010 -> busoutkeep=16'b0000_0010_1010_1010, trunc=1, credits=0.
- MODE1, credits=4, keep=16'h00FF valid -> businrdy=0. Pulse credret=4 -> businrdy=1 on the next cycle. Beat passes with keep 00FF, credits=0.
- Backpressure: busoutrdy=0 for 3 cycles with a beat held -> busoutvld/keep/busout stable, businrdy=0. A credret=8 during the hold makes credits rise by 8 with no consumption.
- Saturation: credits=30, credret=8, no input -> credits=32, credovf=1 and stays 1. Simultaneous accept consuming 16 plus credret=10 from credits 32 -> credits=26, no further overflow.
- Reset mid-stream, asserted asynchronously while busoutvld=1 -> busoutvld drops immediately, credits=CREDITINIT, credovf=0. First beat after release behaves as from reset.
